// File: rtl/button_step_ctrl_if.sv
// Button-side bundle of the step controller: raw buttons in, Counter control code and held flag out.
interface button_step_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [1:0] control;
    logic       held;

    modport master (
        output btn_up,
        output btn_down,
        output btn_clr,
        input  control,
        input  held
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_clr,
        output control,
        output held
    );
endinterface

// File: rtl/button_step_ctrl.sv
// Push-button front end for the up/down Counter: sync, debounce, single step on press,
// auto-repeat while held, and a one-cycle clear pulse that wins over any step.
module button_step_ctrl #(
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic                clk,
    input logic                rst,
    button_step_ctrl_if.slave  bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0] DLY_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PER_LAST = TM_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] CTL_HOLD = 2'b00;
    localparam logic [1:0] CTL_UP   = 2'b01;
    localparam logic [1:0] CTL_DOWN = 2'b10;
    localparam logic [1:0] CTL_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_DLY = 2'd1,
        REPEAT   = 2'd2
    } state_t;

    // Bit order in the per-button vectors: 0 = up, 1 = down, 2 = clear.
    logic [2:0]      btn_s;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic            clr_prev_q;

    state_t          state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            dir_q, dir_d;
    logic [1:0]      control_q, control_d;
    logic            held_q, held_d;

    logic            dir_valid_s;
    logic            dir_s;
    logic            step_s;
    logic            clr_rise_s;

    assign btn_s       = {bus.btn_clr, bus.btn_down, bus.btn_up};
    assign dir_valid_s = db_q[0] ^ db_q[1];
    assign dir_s       = db_q[1];
    assign clr_rise_s  = db_q[2] & ~clr_prev_q;

    // Per-button debounce: flip only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = {DB_W{1'b0}};
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end
        end
    end

    // Step FSM with one shared timer; clear overrides any step issued in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = {TM_W{1'b0}};
                if (dir_valid_s) begin
                    step_s  = 1'b1;
                    dir_d   = dir_s;
                    state_d = HOLD_DLY;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD_DLY, REPEAT: begin
                if (!dir_valid_s || (dir_s != dir_q)) begin
                    state_d = IDLE;
                    timer_d = {TM_W{1'b0}};
                end else if (timer_q == ((state_q == HOLD_DLY) ? DLY_LAST : PER_LAST)) begin
                    step_s  = 1'b1;
                    state_d = REPEAT;
                    timer_d = {TM_W{1'b0}};
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = {TM_W{1'b0}};
            end
        endcase

        if (clr_rise_s) begin
            control_d = CTL_CLR;
        end else if (step_s) begin
            control_d = dir_d ? CTL_DOWN : CTL_UP;
        end else begin
            control_d = CTL_HOLD;
        end
        held_d = (state_d != IDLE);
    end

    // State registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            db_q       <= 3'b000;
            clr_prev_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
            end
            state_q    <= IDLE;
            timer_q    <= {TM_W{1'b0}};
            dir_q      <= 1'b0;
            control_q  <= CTL_HOLD;
            held_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_s;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            clr_prev_q <= db_q[2];
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            control_q  <= control_d;
            held_q     <= held_d;
        end
    end

    assign bus.control = control_q;
    assign bus.held    = held_q;

endmodule
